// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, read-latency-1 on-chip RAM
// between two Avalon-MM requesters; read data is routed back to its issuer.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic req_0;
  logic req_1;
  logic any_req;
  logic grant_sel;
  logic sel;
  logic granted_write;
  logic rd_accept;

  logic prio;
  logic rd_pend;
  logic rd_owner;

  assign req_0   = m0_read | m0_write;
  assign req_1   = m1_read | m1_write;
  assign any_req = req_0 | req_1;

  // Only contention consults the pointer; a lone requester always wins.
  assign grant_sel = (req_0 & req_1) ? prio : req_1;

  // When idle, steer the mux to the port granted last (prio points away
  // from it), so mem_address keeps presenting that port's address.
  assign sel = any_req ? grant_sel : ~prio;

  assign mem_address    = sel ? m1_address    : m0_address;
  assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
  assign granted_write  = sel ? m1_write      : m0_write;

  assign mem_chipselect = any_req;
  assign mem_write      = any_req & granted_write;
  assign mem_clken      = 1'b1;

  assign rd_accept = any_req & ~granted_write;

  assign m0_waitrequest = req_0 & grant_sel;
  assign m1_waitrequest = req_1 & ~grant_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio     <= 1'b0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (any_req) begin
        prio <= ~grant_sel;
      end
      rd_pend <= rd_accept;
      if (rd_accept) begin
        rd_owner <= grant_sel;
      end
    end
  end

  // The RAM's fixed one-cycle latency means a single owner bit suffices.
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend &  rd_owner;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM plus a transaction-level
// reference model; directed scenarios followed by randomized traffic.
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10240;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m1_read, m0_write, m1_write;
  logic [31:0]       m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h00010003) ^ 32'hA5A50000;
  endfunction

  // Behavioural single-port RAM with one cycle of read latency.
  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  // Requester state: a request stays up until the model says it was taken.
  bit          act [2];
  bit          wr [2];
  bit          both [2];
  logic [13:0] adr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];
  bit          sticky;
  bit          rand_mode;

  // Reference model: memory contents, fairness pointer, expected return.
  logic [31:0] model_mem [0:DEPTH-1];
  int          favour;
  bit          rv_valid;
  int          rv_port;
  logic [31:0] rv_data;
  logic [31:0] last_rd [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive_ports();
    m0_read       = act[0] && (!wr[0] || both[0]);
    m0_write      = act[0] && wr[0];
    m0_address    = adr[0];
    m0_byteenable = be[0];
    m0_writedata  = wd[0];
    m1_read       = act[1] && (!wr[1] || both[1]);
    m1_write      = act[1] && wr[1];
    m1_address    = adr[1];
    m1_byteenable = be[1];
    m1_writedata  = wd[1];
  endtask

  task automatic apply_stimulus();
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && $urandom_range(9) < 6) begin
          act[i]  = 1'b1;
          wr[i]   = 1'($urandom_range(1));
          both[i] = wr[i] && ($urandom_range(3) == 0);
          adr[i]  = ($urandom_range(4) == 0) ? 14'h27FF : 14'($urandom_range(7));
          be[i]   = 4'($urandom_range(15));
          wd[i]   = $urandom;
        end
      end
    end
    drive_ports();
  endtask

  task automatic set_req(input int p, input bit w, input logic [13:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    act[p] = 1'b1; wr[p] = w; both[p] = 1'b0; adr[p] = a; be[p] = b; wd[p] = d;
  endtask

  // One bus cycle: drive, check at the falling edge, advance the model.
  task automatic step();
    int w;
    bit any;
    apply_stimulus();
    @(negedge clk);
    any = act[0] || act[1];
    if (act[0] && act[1]) w = favour;
    else if (act[1]) w = 1;
    else w = 0;
    check_output("wait0", 32'(m0_waitrequest), 32'(act[0] && any && (w != 0)));
    check_output("wait1", 32'(m1_waitrequest), 32'(act[1] && any && (w != 1)));
    check_output("chipselect", 32'(mem_chipselect), 32'(any));
    check_output("clken", 32'(mem_clken), 32'd1);
    check_output("rdvalid0", 32'(m0_readdatavalid), 32'(rv_valid && rv_port == 0));
    check_output("rdvalid1", 32'(m1_readdatavalid), 32'(rv_valid && rv_port == 1));
    if (rv_valid && rv_port == 0) check_output("readdata0", m0_readdata, rv_data);
    if (rv_valid && rv_port == 1) check_output("readdata1", m1_readdata, rv_data);
    if (m0_readdatavalid) last_rd[0] = m0_readdata;
    if (m1_readdatavalid) last_rd[1] = m1_readdata;
    if (any) begin
      check_output("mem_write", 32'(mem_write), 32'(wr[w]));
      check_output("mem_address", 32'(mem_address), 32'(adr[w]));
      if (wr[w]) begin
        check_output("mem_writedata", mem_writedata, wd[w]);
        check_output("mem_byteenable", 32'(mem_byteenable), 32'(be[w]));
        model_mem[adr[w]] = merge(model_mem[adr[w]], wd[w], be[w]);
        rv_valid = 1'b0;
      end else begin
        check_output("mem_write", 32'(mem_write), 32'd0);
        rv_valid = 1'b1;
        rv_port  = w;
        rv_data  = model_mem[adr[w]];
      end
      favour = 1 - w;
      if (!sticky) act[w] = 1'b0;
    end else begin
      check_output("mem_write", 32'(mem_write), 32'd0);
      rv_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle();
    for (int k = 0; k < 10 && (act[0] || act[1]); k++) step();
  endtask

  task automatic do_reset();
    act[0] = 1'b0; act[1] = 1'b0;
    drive_ports();
    reset_n = 1'b0;
    #1;
    check_output("rst_rdvalid0", 32'(m0_readdatavalid), 32'd0);
    check_output("rst_rdvalid1", 32'(m1_readdatavalid), 32'd0);
    check_output("rst_chipselect", 32'(mem_chipselect), 32'd0);
    favour   = 0;
    rv_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bdata;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]       = init_word(i);
      model_mem[i] = init_word(i);
    end
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; wr[i] = 1'b0; both[i] = 1'b0;
      adr[i] = '0; be[i] = '0; wd[i] = '0; last_rd[i] = '0;
    end
    sticky = 1'b0; rand_mode = 1'b0; favour = 0; rv_valid = 1'b0; rv_port = 0; rv_data = '0;
    reset_n = 1'b0;
    drive_ports();
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] reset state and first contention");
    step();
    set_req(0, 1'b0, 14'h0001, 4'hF, 32'h0);
    set_req(1, 1'b0, 14'h0002, 4'hF, 32'h0);
    run_until_idle();
    step();

    $display("[TB] reset during a pending read");
    set_req(0, 1'b0, 14'h0005, 4'hF, 32'h0);
    step();
    do_reset();
    set_req(1, 1'b0, 14'h0010, 4'hF, 32'h0);
    step();
    step();

    $display("[TB] simultaneous write and read");
    last_rd[1] = '0;
    set_req(0, 1'b1, 14'h0200, 4'hF, 32'h12345678);
    set_req(1, 1'b0, 14'h0200, 4'hF, 32'h0);
    run_until_idle();
    step();
    check_output("wr_then_rd", last_rd[1], 32'h12345678);

    $display("[TB] single port write/read");
    last_rd[0] = '0;
    set_req(0, 1'b1, 14'h0100, 4'hF, 32'hDEADBEEF);
    run_until_idle();
    set_req(0, 1'b0, 14'h0100, 4'hF, 32'h0);
    run_until_idle();
    step();
    check_output("single_port", last_rd[0], 32'hDEADBEEF);

    $display("[TB] byte lanes");
    last_rd[1] = '0;
    set_req(1, 1'b1, 14'h0300, 4'hF, 32'hAAAAAAAA);
    run_until_idle();
    set_req(1, 1'b1, 14'h0300, 4'h5, 32'h11223344);
    run_until_idle();
    set_req(1, 1'b0, 14'h0300, 4'hF, 32'h0);
    run_until_idle();
    step();
    check_output("byte_lanes", last_rd[1], 32'hAA22AA44);

    $display("[TB] continuous contention");
    sticky = 1'b1;
    set_req(0, 1'b0, 14'h0001, 4'hF, 32'h0);
    set_req(1, 1'b0, 14'h0002, 4'hF, 32'h0);
    for (int k = 0; k < 8; k++) step();
    sticky = 1'b0;
    run_until_idle();
    step();

    $display("[TB] boundary address with idle gap");
    bdata = 32'hC0FFEE01;
    last_rd[0] = '0;
    set_req(0, 1'b1, 14'h27FF, 4'hF, bdata);
    run_until_idle();
    step();
    set_req(0, 1'b0, 14'h27FF, 4'hF, 32'h0);
    run_until_idle();
    step();
    check_output("boundary", last_rd[0], bdata);

    $display("[TB] randomized traffic");
    rand_mode = 1'b1;
    for (int k = 0; k < 3000; k++) step();
    rand_mode = 1'b0;
    run_until_idle();
    step();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 40 KiB on-chip RAM (10240 × 32-bit, byte-enabled, read latency 1) between two Avalon-MM requesters, e.g. the Nios II data master and a DMA master. It sits between the masters and the memory's s1 slave. It accepts at most one transfer per clock, grants fairly, stalls the loser with waitrequest, and routes the read data back to the port that issued the read.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the memory
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address from requester 0 / 1
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid for this port
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; constant 1
- mem_readdata  in  DATA_W  from RAM (valid the cycle after the read is presented)

## Operation
- Request: req_x = mx_read | mx_write. If mx_read and mx_write are both asserted, the request is treated as a write.
- Priority pointer `prio` (1 bit) names the favoured port. Reset value is 0.
- Grant (combinational):
  - Only req_0 asserted: grant 0.
  - Only req_1 asserted: grant 1.
  - Both asserted: grant prio.
  - Neither asserted: no grant.
- On any accepted transfer, prio <= ~granted port. Otherwise prio holds.
- Granted port:
  - Its signals are muxed onto mem_*.
  - mem_chipselect = 1; mem_write = granted write.
  - mx_waitrequest = 0.
- Non-granted requesting port: mx_waitrequest = 1. It must hold its request stable until accepted.
- Idle port: waitrequest = 0. Avalon permits this; it has no effect.
- No request: mem_chipselect = 0, mem_write = 0, mem_address holds the last granted value.
- Read return tracking:
  - rd_pend <= accepted-read this cycle.
  - rd_owner <= granted port on an accepted read.
  - mx_readdatavalid = rd_pend & (rd_owner == x).
  - mx_readdata = mem_readdata for both ports (pass-through); the data is qualified only by readdatavalid.
- Fixed read latency of 1 means no response queue is needed. Back-to-back reads from alternating ports each return on their own port.
- Writes generate no response.

## Timing
- Reset values: prio=0, rd_pend=0, rd_owner=0. Consequently all readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=1, and all waitrequest=0 when no request is present.
- Asynchronous reset: assertion clears the registers immediately; release is sampled on the next clk rising edge.
- Accept: in the same cycle the request is presented, with zero added latency when uncontended.
- Read data: mx_readdatavalid is high exactly 1 cycle after the accepting edge, for one cycle.
- Contention: the loser waits exactly 1 cycle if the winner does not request again. With both ports requesting continuously, grants alternate 0,1,0,1,… so neither port waits more than 1 cycle.
- Throughput: one transfer per cycle, with reads and writes in any mix.
- Read followed by a write on the next cycle: the read data still returns correctly. The RAM is single-port, but the read output was already registered by address on the prior edge.
- Reset mid-read: rd_pend clears and the pending readdatavalid is dropped; requesters must reissue the read.
- All waitrequest, grant and mem_* outputs are combinational from the requests and prio. The only registers are prio, rd_pend and rd_owner.

## Test plan
- Reset: assert reset_n=0 mid-stream -> prio=0, readdatavalid both 0, mem_chipselect=0 asynchronously. After release, a m1 read of address 0x0010 is granted immediately.
- Single port: m0 writes 0xDEADBEEF to 0x0100 with byteenable 0xF, then reads 0x0100 -> m0_readdatavalid high 1 cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: m1 writes 0x11223344 with byteenable 0x5 over a location holding 0xAAAAAAAA -> subsequent read returns 0xAA22AA44.
- Contention: both ports read (m0 @0x0001, m1 @0x0002) continuously from reset -> grants m0, m1, m0, … Each readdatavalid is on the correct port and the data matches its own address; the loser's waitrequest is high for exactly 1 cycle per grant.
- Simultaneous write/read: m0 writes 0x12345678 to 0x0200 while m1 reads 0x0200 with prio=0 -> write accepted first, then the m1 read is accepted next cycle and returns 0x12345678.
- Boundary address: m0 writes and reads word 10239 (0x27FF) -> data round-trips. An idle cycle between transfers leaves mem_chipselect=0 and produces no readdatavalid.
